axil_addr_decoder_rd: RTL and testbench
=======================================

// Module: axil_addr_decoder_rd
// PURPOSE
// - Read-channel address decoder between one AXI-Lite master and SLV_NUM slaves.
// - Accepts one read address, decodes it and forwards AR to the matching slave.
// - Routes that slave's R channel back to the master; one outstanding read only.
// - Unmapped addresses raise slv_invalid to the DECERR responder (axil_response_addr_invalid_rd).
//   The responder's R channel is then routed back to the master.
// PARAMETERS
// AXI_DATA_WIDTH  32              data bus width
// AXI_ADDR_WIDTH  32              address bus width
// SLV_NUM         4               number of downstream slaves (>=1)
// SLV_BASE        {SLV_NUM{32'h0}} packed [SLV_NUM][AXI_ADDR_WIDTH] base address per slave
// SLV_MASK        {SLV_NUM{32'h0}} packed [SLV_NUM][AXI_ADDR_WIDTH] decode mask per slave
// PORTS
// aclk            in   1                    clock
// aresetn         in   1                    reset, synchronous, active-low
// s_axil_araddr   in   AXI_ADDR_WIDTH       master read address
// s_axil_arprot   in   3                    master prot
// s_axil_arvalid  in   1                    master AR valid
// s_axil_arready  out  1                    master AR ready (registered)
// s_axil_rdata    out  AXI_DATA_WIDTH       master read data (muxed)
// s_axil_rresp    out  2                    master read resp (muxed)
// s_axil_rvalid   out  1                    master R valid (muxed)
// s_axil_rready   in   1                    master R ready
// m_axil_araddr   out  AXI_ADDR_WIDTH       address to all slaves (shared, registered)
// m_axil_arprot   out  3                    prot to all slaves (shared, registered)
// m_axil_arvalid  out  SLV_NUM              per-slave AR valid, at most one bit high
// m_axil_arready  in   SLV_NUM              per-slave AR ready
// m_axil_rdata    in   SLV_NUM*AXI_DATA_WIDTH per-slave read data
// m_axil_rresp    in   SLV_NUM*2            per-slave read resp
// m_axil_rvalid   in   SLV_NUM              per-slave R valid
// m_axil_rready   out  SLV_NUM              per-slave R ready, at most one bit high
// slv_invalid     out  1                    request to DECERR responder
// inv_arready     in   1                    responder AR-accept pulse
// inv_rdata       in   AXI_DATA_WIDTH       responder read data
// inv_rresp       in   2                    responder read resp
// inv_rvalid      in   1                    responder R valid
// inv_rready      out  1                    responder R ready
// BEHAVIOUR
// - Reset: state=IDLE. s_axil_arready, m_axil_arvalid, slv_invalid=0.
//   m_axil_araddr, m_axil_arprot, sel_q=0. R mux outputs 0 (no path selected).
// - IDLE: s_axil_arready<=1. On arvalid&&arready: latch addr/prot, arready<=0, ->DECODE.
// - DECODE (1 cycle): hit[i] = (addr & SLV_MASK[i]) == SLV_BASE[i].
//   Lowest matching index wins; register sel_q.
//   Any hit -> ADDR with m_axil_arvalid[sel_q]<=1. No hit -> INV with slv_invalid<=1.
// - ADDR: hold arvalid until m_axil_arready[sel_q]; then clear it, ->DATA.
//   Earliest m_axil_arvalid: 2 cycles after master AR handshake.
// - INV: hold slv_invalid until inv_arready=1; then clear it, ->DATA.
// - DATA: combinational pass-through of s_axil_r* from slave sel_q, or from inv_* if invalid.
//   Selected rready=s_axil_rready; all other rready=0.
//   On s_axil_rvalid&&s_axil_rready -> IDLE. The path is deselected in that same cycle.
// - Outside DATA: s_axil_rvalid=0. Unsolicited slave/responder rvalid is ignored (its rready=0).
// - Stalls: arready or rready held low keeps the current state indefinitely; no timeout.
// - Simultaneous: R handshake in DATA and new master arvalid -> arvalid not accepted that cycle.
//   IDLE raises arready on the next cycle.
// - Reset mid-operation: the transaction is dropped. All outputs return to reset values next edge.
// - Widths: address compare is the full AXI_ADDR_WIDTH. SLV_MASK=0 matches everything.
// STRUCTURE
// - Package axil_ic_pkg: state enum {IDLE,DECODE,ADDR,INV,DATA}.
//   Resp constants RESP_OKAY=2'b00, RESP_DECERR=2'b11.
// - Sub-module axil_addr_match: combinational priority match of addr vs SLV_BASE/SLV_MASK.
//   Outputs sel index plus hit flag.
// - Everything else (FSM, R mux) lives in this module.
// TESTING (SLV_NUM=2; slv0 base 0x0000_0000 mask 0xFFFF_0000; slv1 base 0x0001_0000 mask 0xFFFF_0000)
// - Read 0x0000_0010: m_arvalid=2'b01, addr 0x10.
//   slv0 returns 0xDEAD_BEEF/OKAY -> master sees 0xDEAD_BEEF, rresp=00, one beat.
// - Read 0x0001_0004: m_arvalid=2'b10. m_arready held 0 for 5 cycles.
//   arvalid stays high and stable, then one handshake, then R routed from slv1.
// - Read 0x0002_0000: slv_invalid=1 until inv_arready.
//   Responder beat rdata=0/rresp=11 reaches master. m_arvalid stays 0.
// - s_axil_rready=0 for 4 cycles in DATA: rvalid and rdata held, rready to slave=0.
//   Then handshake -> IDLE, s_arready=1 next cycle.
// - Back-to-back reads 0x0, 0x1_0000, 0x3_0000: correct order and resp (00, 00, 11).
//   Never two m_arvalid bits high.
// - aresetn=0 while in ADDR with slv1 selected: next edge m_arvalid=0, slv_invalid=0, arready=0.
//   After release, IDLE and a fresh read completes.

Source files
------------

// File: rtl/axil_ic_pkg.sv
// Shared types and constants for the AXI-Lite read address decoder.
// The state enum and response codes are also used by the testbench.
package axil_ic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ADDR,
    INV,
    DATA
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of a slave index; a single slave still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_addr_decoder_rd_if.sv
// Bundle of the bus signals around the read decoder: upstream master, fanned-out slaves, DECERR responder.
// The slave modport is the decoder's own view; the master modport is the surrounding system.
interface axil_addr_decoder_rd_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int SLV_NUM        = 4
);

  logic [AXI_ADDR_WIDTH-1:0]         s_axil_araddr;
  logic [2:0]                        s_axil_arprot;
  logic                              s_axil_arvalid;
  logic                              s_axil_arready;
  logic [AXI_DATA_WIDTH-1:0]         s_axil_rdata;
  logic [1:0]                        s_axil_rresp;
  logic                              s_axil_rvalid;
  logic                              s_axil_rready;

  logic [AXI_ADDR_WIDTH-1:0]         m_axil_araddr;
  logic [2:0]                        m_axil_arprot;
  logic [SLV_NUM-1:0]                m_axil_arvalid;
  logic [SLV_NUM-1:0]                m_axil_arready;
  logic [SLV_NUM*AXI_DATA_WIDTH-1:0] m_axil_rdata;
  logic [SLV_NUM*2-1:0]              m_axil_rresp;
  logic [SLV_NUM-1:0]                m_axil_rvalid;
  logic [SLV_NUM-1:0]                m_axil_rready;

  logic                              slv_invalid;
  logic                              inv_arready;
  logic [AXI_DATA_WIDTH-1:0]         inv_rdata;
  logic [1:0]                        inv_rresp;
  logic                              inv_rvalid;
  logic                              inv_rready;

  modport slave (
    input  s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
    output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready,
    input  m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    output slv_invalid, inv_rready,
    input  inv_arready, inv_rdata, inv_rresp, inv_rvalid
  );

  modport master (
    output s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
    input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    input  m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready,
    output m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    input  slv_invalid, inv_rready,
    output inv_arready, inv_rdata, inv_rresp, inv_rvalid
  );

endinterface

// File: rtl/axil_addr_decoder_rd_addr_match.sv
// Combinational priority match of an address against per-slave base/mask windows.
// Lowest matching index wins; hit is low when no window claims the address.
module axil_addr_match #(
  parameter int                                  AXI_ADDR_WIDTH = 32,
  parameter int                                  SLV_NUM        = 4,
  parameter int                                  SEL_W          = 2,
  parameter logic [SLV_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLV_BASE      = '0,
  parameter logic [SLV_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLV_MASK      = '0
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [SEL_W-1:0]          sel,
  output logic                      hit
);

  logic [SLV_NUM-1:0] hit_vec;

  generate
    for (genvar gi = 0; gi < SLV_NUM; gi++) begin : g_hit
      assign hit_vec[gi] = (addr & SLV_MASK[gi]) == SLV_BASE[gi];
    end
  endgenerate

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    sel = '0;
    for (int i = SLV_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) sel = SEL_W'(i);
    end
  end

  assign hit = |hit_vec;

endmodule

// File: rtl/axil_addr_decoder_rd.sv
// AXI-Lite read-channel decoder: one master, SLV_NUM slaves plus a DECERR responder.
// A single read is in flight at a time; the R path is a combinational mux selected by the FSM.
module axil_addr_decoder_rd
  import axil_ic_pkg::*;
#(
  parameter int                                  AXI_DATA_WIDTH = 32,
  parameter int                                  AXI_ADDR_WIDTH = 32,
  parameter int                                  SLV_NUM        = 4,
  parameter logic [SLV_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLV_BASE      = '0,
  parameter logic [SLV_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLV_MASK      = '0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axil_addr_decoder_rd_if.slave bus
);

  localparam int SEL_W = sel_width(SLV_NUM);

  state_t                    state_reg;
  logic                      arready_reg;
  logic [AXI_ADDR_WIDTH-1:0] araddr_reg;
  logic [2:0]                arprot_reg;
  logic [SLV_NUM-1:0]        arvalid_reg;
  logic                      slv_invalid_reg;
  logic [SEL_W-1:0]          sel_reg;
  logic                      inv_reg;

  logic [SEL_W-1:0]          match_sel;
  logic                      match_hit;
  logic                      data_phase;
  logic                      r_fire;

  logic [AXI_DATA_WIDTH-1:0] slv_rdata [SLV_NUM];
  logic [1:0]                slv_rresp [SLV_NUM];
  logic                      slv_rvalid [SLV_NUM];

  axil_addr_match #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .SLV_NUM        (SLV_NUM),
    .SEL_W          (SEL_W),
    .SLV_BASE       (SLV_BASE),
    .SLV_MASK       (SLV_MASK)
  ) u_match (
    .addr (araddr_reg),
    .sel  (match_sel),
    .hit  (match_hit)
  );

  assign data_phase = (state_reg == DATA);

  generate
    for (genvar gi = 0; gi < SLV_NUM; gi++) begin : g_slv
      assign slv_rdata[gi]  = bus.m_axil_rdata[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      assign slv_rresp[gi]  = bus.m_axil_rresp[gi*2 +: 2];
      assign slv_rvalid[gi] = bus.m_axil_rvalid[gi];
      // Only the slave that owns the outstanding read ever sees rready.
      assign bus.m_axil_rready[gi] = data_phase && !inv_reg && (sel_reg == SEL_W'(gi)) &&
                                     bus.s_axil_rready;
    end
  endgenerate

  assign bus.inv_rready = data_phase && inv_reg && bus.s_axil_rready;

  always_comb begin
    bus.s_axil_rdata  = '0;
    bus.s_axil_rresp  = '0;
    bus.s_axil_rvalid = 1'b0;
    if (data_phase) begin
      if (inv_reg) begin
        bus.s_axil_rdata  = bus.inv_rdata;
        bus.s_axil_rresp  = bus.inv_rresp;
        bus.s_axil_rvalid = bus.inv_rvalid;
      end else begin
        bus.s_axil_rdata  = slv_rdata[sel_reg];
        bus.s_axil_rresp  = slv_rresp[sel_reg];
        bus.s_axil_rvalid = slv_rvalid[sel_reg];
      end
    end
  end

  assign r_fire = bus.s_axil_rvalid && bus.s_axil_rready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      arready_reg     <= 1'b0;
      araddr_reg      <= '0;
      arprot_reg      <= '0;
      arvalid_reg     <= '0;
      slv_invalid_reg <= 1'b0;
      sel_reg         <= '0;
      inv_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          arready_reg <= 1'b1;
          if (bus.s_axil_arvalid && arready_reg) begin
            araddr_reg  <= bus.s_axil_araddr;
            arprot_reg  <= bus.s_axil_arprot;
            arready_reg <= 1'b0;
            state_reg   <= DECODE;
          end
        end
        DECODE: begin
          sel_reg <= match_sel;
          inv_reg <= !match_hit;
          if (match_hit) begin
            arvalid_reg[match_sel] <= 1'b1;
            state_reg              <= ADDR;
          end else begin
            slv_invalid_reg <= 1'b1;
            state_reg       <= INV;
          end
        end
        ADDR: begin
          if (bus.m_axil_arready[sel_reg]) begin
            arvalid_reg <= '0;
            state_reg   <= DATA;
          end
        end
        INV: begin
          if (bus.inv_arready) begin
            slv_invalid_reg <= 1'b0;
            state_reg       <= DATA;
          end
        end
        DATA: begin
          if (r_fire) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.s_axil_arready = arready_reg;
  assign bus.m_axil_araddr  = araddr_reg;
  assign bus.m_axil_arprot  = arprot_reg;
  assign bus.m_axil_arvalid = arvalid_reg;
  assign bus.slv_invalid    = slv_invalid_reg;

endmodule

// File: tb/tb_axil_addr_decoder_rd.sv
// Testbench for axil_addr_decoder_rd with two 64 KiB slave windows and a DECERR responder.
// Table vectors, randomized reads against a region-based reference model, and reset/stall sequences.
module tb_axil_addr_decoder_rd;
  import axil_ic_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int N  = 2;
  localparam logic [N-1:0][AW-1:0] BASE = {32'h0001_0000, 32'h0000_0000};
  localparam logic [N-1:0][AW-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000};

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axil_addr_decoder_rd_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .SLV_NUM(N)) bus ();

  axil_addr_decoder_rd #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .SLV_NUM        (N),
    .SLV_BASE       (BASE),
    .SLV_MASK       (MASK)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    int          ar_dly;
    int          r_dly;
    logic [31:0] beat;
    int          exp_tgt;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference decode: each slave owns one 64 KiB region; everything else is unmapped.
  function automatic int ref_target(input logic [31:0] a);
    int unsigned region;
    region = a / 32'h0001_0000;
    if (region == 0) return 0;
    if (region == 1) return 1;
    return -1;
  endfunction

  task automatic idle_inputs();
    bus.s_axil_arvalid = 1'b0;
    bus.s_axil_araddr  = '0;
    bus.s_axil_arprot  = '0;
    bus.s_axil_rready  = 1'b0;
    bus.m_axil_arready = '0;
    bus.m_axil_rdata   = '0;
    bus.m_axil_rresp   = '0;
    bus.m_axil_rvalid  = '0;
    bus.inv_arready    = 1'b0;
    bus.inv_rdata      = '0;
    bus.inv_rresp      = '0;
    bus.inv_rvalid     = 1'b0;
  endtask

  // One full read. Slaves accept AR after ar_dly request cycles, master stalls R for r_dly cycles,
  // non-owning slaves and the responder throw random unsolicited rvalid at the decoder.
  task automatic read_txn(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          input logic [31:0] beat, input int exp_t, input logic [31:0] exp_d,
                          input logic [1:0] exp_r, input string tag);
    int          acc, acc_before, cyc, hs_cyc, first_req, ar_wait, r_wait, perr;
    bit          ar_done, done, prev_held, prev_rstall;
    logic [2:0]  prot, acc_prot;
    logic [31:0] acc_addr, got_d, held_d;
    logic [1:0]  got_r;
    logic [N-1:0] prev_arv;
    acc = -2; cyc = 0; hs_cyc = -1; first_req = -1; ar_wait = 0; r_wait = 0; perr = 0;
    ar_done = 0; done = 0; prev_held = 0; prev_rstall = 0;
    prot = 3'($urandom_range(0, 7)); acc_prot = '0; acc_addr = '0; got_d = '0; held_d = '0;
    got_r = '0; prev_arv = '0;
    while (!done && cyc < 300) begin
      @(negedge aclk);
      bus.s_axil_arvalid = !ar_done;
      bus.s_axil_araddr  = ar_done ? $urandom : addr;
      bus.s_axil_arprot  = prot;
      for (int k = 0; k < N; k++) begin
        bus.m_axil_arready[k] = bus.m_axil_arvalid[k] && (ar_wait >= ar_dly);
        if (acc == k) begin
          bus.m_axil_rvalid[k]          = 1'b1;
          bus.m_axil_rdata[k*DW +: DW]  = beat;
          bus.m_axil_rresp[k*2 +: 2]    = RESP_OKAY;
        end else begin
          bus.m_axil_rvalid[k]          = 1'($urandom_range(0, 1));
          bus.m_axil_rdata[k*DW +: DW]  = ~beat;
          bus.m_axil_rresp[k*2 +: 2]    = 2'b10;
        end
      end
      bus.inv_arready   = bus.slv_invalid && (ar_wait >= ar_dly);
      bus.inv_rvalid    = (acc == -1) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.inv_rdata     = (acc == -1) ? 32'h0 : $urandom;
      bus.inv_rresp     = (acc == -1) ? RESP_DECERR : RESP_OKAY;
      bus.s_axil_rready = (acc != -2) && (r_wait >= r_dly);
      #1;
      acc_before = acc;
      if ($countones(bus.m_axil_arvalid) > 1) perr++;
      if (prev_held && (bus.m_axil_arvalid != prev_arv || bus.m_axil_araddr != addr)) perr++;
      if (acc_before == -2 && bus.s_axil_rvalid) perr++;
      for (int k = 0; k < N; k++)
        if (bus.m_axil_rready[k] && acc_before != k) perr++;
      if (bus.inv_rready && acc_before != -1) perr++;
      if (prev_rstall && (!bus.s_axil_rvalid || bus.s_axil_rdata != held_d)) perr++;
      if (bus.m_axil_arvalid != '0 || bus.slv_invalid) begin
        if (first_req < 0) first_req = cyc;
        ar_wait++;
      end
      if (bus.s_axil_arvalid && bus.s_axil_arready) begin
        ar_done = 1;
        hs_cyc  = cyc;
      end
      prev_held = 0;
      for (int k = 0; k < N; k++) begin
        if (bus.m_axil_arvalid[k]) begin
          if (bus.m_axil_arready[k]) begin
            acc      = k;
            acc_addr = bus.m_axil_araddr;
            acc_prot = bus.m_axil_arprot;
          end else begin
            prev_held = 1;
          end
        end
      end
      prev_arv = bus.m_axil_arvalid;
      if (bus.slv_invalid && bus.inv_arready) acc = -1;
      if (acc_before != -2 && bus.s_axil_rvalid && bus.s_axil_rready) begin
        done  = 1;
        got_d = bus.s_axil_rdata;
        got_r = bus.s_axil_rresp;
      end
      prev_rstall = bus.s_axil_rvalid && !bus.s_axil_rready;
      held_d      = bus.s_axil_rdata;
      if (acc_before != -2) r_wait++;
      cyc++;
    end
    check({tag, " done"}, 64'(done), 64'(1));
    check({tag, " target"}, 64'(acc), 64'(exp_t));
    if (exp_t >= 0) begin
      check({tag, " m_araddr"}, 64'(acc_addr), 64'(addr));
      check({tag, " m_arprot"}, 64'(acc_prot), 64'(prot));
    end
    check({tag, " req_latency"}, 64'(first_req - hs_cyc), 64'(2));
    check({tag, " rdata"}, 64'(got_d), 64'(exp_d));
    check({tag, " rresp"}, 64'(got_r), 64'(exp_r));
    check({tag, " protocol"}, 64'(perr), 64'(0));
    // The cycle right after the R handshake the decoder is back in IDLE with arready still low.
    @(negedge aclk);
    idle_inputs();
    #1;
    check({tag, " arready_after_r"}, 64'(bus.s_axil_arready), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          tgt;
    int          region;
    bit          seen;
    logic [31:0] a, b;

    vecs[0] = '{32'h0000_0010, 0, 0, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF, RESP_OKAY};
    vecs[1] = '{32'h0001_0004, 5, 0, 32'h1234_5678,  1, 32'h1234_5678, RESP_OKAY};
    vecs[2] = '{32'h0002_0000, 3, 0, 32'hCAFE_F00D, -1, 32'h0000_0000, RESP_DECERR};
    vecs[3] = '{32'h0000_0040, 0, 4, 32'hA5A5_5A5A,  0, 32'hA5A5_5A5A, RESP_OKAY};
    vecs[4] = '{32'h0000_0000, 0, 0, 32'h1111_1111,  0, 32'h1111_1111, RESP_OKAY};
    vecs[5] = '{32'h0001_0000, 0, 0, 32'h2222_2222,  1, 32'h2222_2222, RESP_OKAY};
    vecs[6] = '{32'h0003_0000, 0, 0, 32'h3333_3333, -1, 32'h0000_0000, RESP_DECERR};

    // Reset state, with slaves and responder waving data that must not leak through.
    idle_inputs();
    bus.m_axil_rvalid = '1;
    bus.m_axil_rdata  = {32'hBAD0_0001, 32'hBAD0_0000};
    bus.inv_rvalid    = 1'b1;
    bus.inv_rdata     = 32'hBAD0_00FF;
    bus.s_axil_rready = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    check("reset arready", 64'(bus.s_axil_arready), 64'(0));
    check("reset m_arvalid", 64'(bus.m_axil_arvalid), 64'(0));
    check("reset slv_invalid", 64'(bus.slv_invalid), 64'(0));
    check("reset m_araddr", 64'(bus.m_axil_araddr), 64'(0));
    check("reset s_rvalid", 64'(bus.s_axil_rvalid), 64'(0));
    check("reset s_rdata", 64'(bus.s_axil_rdata), 64'(0));
    check("reset m_rready", 64'(bus.m_axil_rready), 64'(0));
    check("reset inv_rready", 64'(bus.inv_rready), 64'(0));
    @(negedge aclk);
    idle_inputs();
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    check("post_reset arready", 64'(bus.s_axil_arready), 64'(1));

    for (int i = 0; i < 7; i++) begin
      read_txn(vecs[i].addr, vecs[i].ar_dly, vecs[i].r_dly, vecs[i].beat,
               vecs[i].exp_tgt, vecs[i].exp_data, vecs[i].exp_resp, $sformatf("vec%0d", i));
      if (vecs[i].r_dly > 0) begin
        @(negedge aclk);
        #1;
        check($sformatf("vec%0d arready_reopen", i), 64'(bus.s_axil_arready), 64'(1));
      end
    end

    // Reset while a request to slave 1 is held waiting for arready.
    @(negedge aclk);
    bus.s_axil_arvalid = 1'b1;
    bus.s_axil_araddr  = 32'h0001_0000;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge aclk);
      if (bus.s_axil_arready) bus.s_axil_arvalid = 1'b1;
      #1;
      if (bus.m_axil_arvalid == 2'b10) seen = 1;
      if (bus.s_axil_arvalid && bus.s_axil_arready) begin
        @(negedge aclk);
        bus.s_axil_arvalid = 1'b0;
      end
    end
    check("rst_mid reached ADDR", 64'(seen), 64'(1));
    @(negedge aclk);
    bus.s_axil_arvalid = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    #1;
    check("rst_mid m_arvalid", 64'(bus.m_axil_arvalid), 64'(0));
    check("rst_mid slv_invalid", 64'(bus.slv_invalid), 64'(0));
    check("rst_mid arready", 64'(bus.s_axil_arready), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    check("rst_mid idle arready", 64'(bus.s_axil_arready), 64'(1));
    read_txn(32'h0001_0008, 1, 1, 32'h0BAD_CAFE, 1, 32'h0BAD_CAFE, RESP_OKAY, "after_rst");

    // Randomized reads against the region model.
    for (int i = 0; i < 40; i++) begin
      region = int'($urandom_range(0, 3));
      a = (region == 3) ? $urandom : {16'(region), 16'($urandom)};
      b = $urandom;
      tgt = ref_target(a);
      read_txn(a, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), b, tgt,
               (tgt < 0) ? 32'h0 : b, (tgt < 0) ? RESP_DECERR : RESP_OKAY,
               $sformatf("rnd%0d@%h", i, a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
